// File: rtl/tracking_frame_ctrl_if.sv
// Pixel stream, tracker FIFO/result and published box signals shared between
// the frame controller (slave) and its environment (master).
interface tracking_frame_ctrl_if;
    logic        pix_valid;
    logic        pix_sof;
    logic [23:0] pix_rgb;
    logic        trk_full;
    logic        trk_wr_en;
    logic [23:0] trk_rgb;
    logic        trk_valid;
    logic [11:0] trk_cx;
    logic [11:0] trk_cy;
    logic [11:0] trk_w;
    logic [11:0] trk_h;
    logic        box_valid;
    logic [11:0] box_cx;
    logic [11:0] box_cy;
    logic [11:0] box_w;
    logic [11:0] box_h;
    logic        result_strobe;

    modport master (
        output pix_valid, pix_sof, pix_rgb, trk_full,
        output trk_valid, trk_cx, trk_cy, trk_w, trk_h,
        input  trk_wr_en, trk_rgb,
        input  box_valid, box_cx, box_cy, box_w, box_h, result_strobe
    );

    modport slave (
        input  pix_valid, pix_sof, pix_rgb, trk_full,
        input  trk_valid, trk_cx, trk_cy, trk_w, trk_h,
        output trk_wr_en, trk_rgb,
        output box_valid, box_cx, box_cy, box_w, box_h, result_strobe
    );
endinterface

// File: rtl/tracking_frame_ctrl.sv
// Frame sequencer for the blob tracker: decimates frames, pads short/lossy
// frames to a full raster, then publishes a qualified, held bounding box.
module tracking_frame_ctrl #(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned RES_TIMEOUT = 8192,
    parameter int unsigned MISS_LIMIT  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_enable,
    input  logic [3:0]           cfg_decim,
    tracking_frame_ctrl_if.slave bus,
    output logic                 busy,
    output logic [15:0]          fed_frames,
    output logic [15:0]          err_frames
);
    localparam int unsigned FRAME_PIX = WIDTH * HEIGHT;
    localparam int unsigned WCW       = $clog2(FRAME_PIX + 1);
    localparam int unsigned TW        = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
    localparam logic [WCW-1:0] LAST_WR    = WCW'(FRAME_PIX - 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(RES_TIMEOUT - 1);
    localparam logic [3:0]     MISS_MAX   = 4'(MISS_LIMIT);

    typedef enum logic [2:0] {IDLE, WAIT_SOF, FEED, PAD, WAIT_RES} state_t;

    state_t         state;
    logic [3:0]     decim_cnt;
    logic [WCW-1:0] wr_cnt;
    logic [TW-1:0]  timer;
    logic [3:0]     miss_cnt;
    logic           corrupt;
    logic           sof_hit;
    logic           data_hit;
    logic           take_sof;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        sof_hit  = bus.pix_valid & bus.pix_sof;
        data_hit = bus.pix_valid & ~bus.pix_sof;
        take_sof = (state == WAIT_SOF) & cfg_enable & sof_hit & (decim_cnt == '0);
        bus.trk_wr_en = 1'b0;
        bus.trk_rgb   = bus.pix_rgb;
        case (state)
            IDLE:     bus.trk_rgb   = '0;
            WAIT_SOF: bus.trk_wr_en = take_sof & ~bus.trk_full;
            FEED:     bus.trk_wr_en = data_hit & ~bus.trk_full;
            PAD: begin
                // Zero pixels never match the target colour, so padding is inert.
                bus.trk_wr_en = ~bus.trk_full;
                bus.trk_rgb   = '0;
            end
            default: ;
        endcase
    end

    assign busy = (state == FEED) || (state == PAD) || (state == WAIT_RES);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            decim_cnt         <= '0;
            wr_cnt            <= '0;
            timer             <= '0;
            miss_cnt          <= '0;
            corrupt           <= 1'b0;
            fed_frames        <= '0;
            err_frames        <= '0;
            bus.box_valid     <= 1'b0;
            bus.box_cx        <= '0;
            bus.box_cy        <= '0;
            bus.box_w         <= '0;
            bus.box_h         <= '0;
            bus.result_strobe <= 1'b0;
        end else begin
            bus.result_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_enable) begin
                        state     <= WAIT_SOF;
                        decim_cnt <= '0;
                    end
                end
                WAIT_SOF: begin
                    if (!cfg_enable) begin
                        state <= IDLE;
                    end else if (sof_hit) begin
                        if (decim_cnt != '0) begin
                            decim_cnt <= decim_cnt - 4'd1;
                        end else begin
                            decim_cnt <= cfg_decim;
                            corrupt   <= bus.trk_full;
                            wr_cnt    <= bus.trk_full ? '0 : WCW'(1);
                            state     <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (sof_hit) begin
                        corrupt <= 1'b1;
                        state   <= PAD;
                    end else if (data_hit) begin
                        if (bus.trk_full) begin
                            corrupt <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + WCW'(1);
                            if (wr_cnt == LAST_WR) begin
                                state <= WAIT_RES;
                                timer <= '0;
                            end
                        end
                    end
                end
                PAD: begin
                    if (!bus.trk_full) begin
                        wr_cnt <= wr_cnt + WCW'(1);
                        if (wr_cnt == LAST_WR) begin
                            state <= WAIT_RES;
                            timer <= '0;
                        end
                    end
                end
                WAIT_RES: begin
                    timer <= timer + TW'(1);
                    if (bus.trk_valid) begin
                        if (!corrupt) begin
                            bus.box_cx        <= bus.trk_cx;
                            bus.box_cy        <= bus.trk_cy;
                            bus.box_w         <= bus.trk_w;
                            bus.box_h         <= bus.trk_h;
                            bus.box_valid     <= 1'b1;
                            bus.result_strobe <= 1'b1;
                            miss_cnt          <= '0;
                            fed_frames        <= sat_inc(fed_frames);
                        end else begin
                            err_frames <= sat_inc(err_frames);
                        end
                        state <= cfg_enable ? WAIT_SOF : IDLE;
                    end else if (timer == TIMER_LAST) begin
                        if (corrupt) begin
                            err_frames <= sat_inc(err_frames);
                        end else begin
                            // A clean frame with no target is a miss; the box is kept but disqualified.
                            fed_frames <= sat_inc(fed_frames);
                            if (miss_cnt != 4'hF) miss_cnt <= miss_cnt + 4'd1;
                            if (miss_cnt >= MISS_MAX - 4'd1) bus.box_valid <= 1'b0;
                        end
                        state <= cfg_enable ? WAIT_SOF : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tracking_frame_ctrl.sv
// Randomised scoreboard bench for tracking_frame_ctrl on a 4x2 raster.
module tb_tracking_frame_ctrl;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int TO = 16;
    localparam int ML = 2;

    typedef struct packed {
        logic [11:0] cx;
        logic [11:0] cy;
        logic [11:0] w;
        logic [11:0] h;
    } box_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_enable;
    logic [3:0]  cfg_decim;
    logic        busy;
    logic [15:0] fed_frames;
    logic [15:0] err_frames;

    tracking_frame_ctrl_if bus();

    tracking_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .RES_TIMEOUT(TO), .MISS_LIMIT(ML)) dut (
        .clock(clock), .reset(reset), .cfg_enable(cfg_enable), .cfg_decim(cfg_decim),
        .bus(bus), .busy(busy), .fed_frames(fed_frames), .err_frames(err_frames)
    );

    always #5 clock = ~clock;

    logic [23:0] wr_q[$];
    box_t        box_q[$];
    int total = 0, bad = 0, writes_seen = 0, wr_target = 0;
    int m_skip, m_decim, m_fed, m_err, m_miss;
    bit m_bv;
    box_t m_box;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every tracker write and every result strobe is matched to the queues.
    logic [23:0] e_px;
    box_t        e_box;
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (bus.trk_wr_en === 1'b1) begin
                writes_seen++;
                total++;
                if (wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got rgb %h expected no write at %0t", bus.trk_rgb, $time);
                end else begin
                    e_px = wr_q.pop_front();
                    if (bus.trk_rgb !== e_px || bus.trk_full !== 1'b0) begin
                        bad++;
                        $display("FAIL write_data: got rgb %h full %b expected rgb %h full 0 at %0t",
                                 bus.trk_rgb, bus.trk_full, e_px, $time);
                    end
                end
            end
            if (bus.result_strobe === 1'b1) begin
                total++;
                if (box_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe: got strobe 1 expected 0 at %0t", $time);
                end else begin
                    e_box = box_q.pop_front();
                    if ({bus.box_cx, bus.box_cy, bus.box_w, bus.box_h} !== e_box || bus.box_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL strobe_box: got %0d,%0d,%0d,%0d v%b expected %0d,%0d,%0d,%0d v1",
                                 bus.box_cx, bus.box_cy, bus.box_w, bus.box_h, bus.box_valid,
                                 e_box.cx, e_box.cy, e_box.w, e_box.h);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.trk_full  = 1'b0;
        bus.trk_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_fed"}, fed_frames, m_fed);
        chk({tag, "_err"}, err_frames, m_err);
        chk({tag, "_box_valid"}, bus.box_valid, m_bv);
        chk({tag, "_box"}, ({bus.box_cx, bus.box_cy, bus.box_w, bus.box_h} == m_box) ? 1 : 0, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic set_enable(input int d);
        cfg_enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        cfg_decim  = 4'(d);
        m_decim    = d;
        cfg_enable = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        m_skip = 0;
    endtask

    // kind: 0 clean, 1 drops at pixels 2 and 5, 2 short frame, 3 random drops
    task automatic run_frame(input int kind, input bit give_valid);
        bit fed, corrupt, full;
        int acc, len, guard;
        logic [23:0] px;
        box_t b;
        fed = (m_skip == 0);
        if (fed) m_skip = m_decim; else m_skip--;
        len = (fed && kind == 2) ? int'($urandom_range(N - 1, 1)) : N;
        acc = 0;
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(2, 0)) begin
                idle_inputs();
                @(posedge clock);
                #1;
            end
            full = (i > 0) && ((kind == 1 && (i == 2 || i == 5)) ||
                               (kind == 3 && $urandom_range(2, 0) == 0));
            px = 24'($urandom);
            bus.pix_valid = 1'b1;
            bus.pix_sof   = (i == 0);
            bus.pix_rgb   = px;
            bus.trk_full  = full;
            bus.trk_valid = (i > 0) && ($urandom_range(5, 0) == 0);
            if (fed && !full) begin
                wr_q.push_back(px);
                acc++;
            end
            @(posedge clock);
            #1;
        end
        idle_inputs();
        if (!fed) begin
            chk("skip_busy", busy, 0);
            return;
        end
        corrupt = (acc < N);
        if (corrupt) begin
            bus.pix_valid = 1'b1;
            bus.pix_sof   = 1'b1;
            bus.pix_rgb   = 24'($urandom);
            @(posedge clock);
            #1;
            idle_inputs();
            for (int k = acc; k < N; k++) wr_q.push_back('0);
        end
        wr_target += N;
        guard = 0;
        while (writes_seen < wr_target && guard < 200) begin
            @(posedge clock);
            guard++;
        end
        chk("frame_writes", writes_seen, wr_target);
        if (guard > 0) #1;
        if (give_valid) begin
            repeat ($urandom_range(6, 0)) @(posedge clock);
            #1;
            b = {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
            {bus.trk_cx, bus.trk_cy, bus.trk_w, bus.trk_h} = b;
            bus.trk_valid = 1'b1;
            if (!corrupt) begin
                m_fed++;
                m_box  = b;
                m_bv   = 1'b1;
                m_miss = 0;
                box_q.push_back(b);
            end else begin
                m_err++;
            end
            @(posedge clock);
            #1;
            bus.trk_valid = 1'b0;
        end else if (corrupt) begin
            m_err++;
        end else begin
            m_fed++;
            m_miss++;
            if (m_miss >= ML) m_bv = 1'b0;
        end
        guard = 0;
        while (busy !== 1'b0 && guard < 60) begin
            @(negedge clock);
            guard++;
        end
        check_outputs("frame");
        @(posedge clock);
        #1;
    endtask

    task automatic reset_model();
        m_fed = 0; m_err = 0; m_miss = 0; m_bv = 1'b0; m_box = '0; m_skip = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        cfg_enable = 1'b0;
        cfg_decim  = '0;
        m_decim    = 0;
        idle_inputs();
        bus.pix_valid = 1'b1;
        bus.pix_sof   = 1'b1;
        bus.pix_rgb   = 24'hABCDEF;
        {bus.trk_cx, bus.trk_cy, bus.trk_w, bus.trk_h} = '0;
        reset_model();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs("reset");
        chk("reset_strobe", bus.result_strobe, 0);
        chk("reset_wr_en", bus.trk_wr_en, 0);
        chk("reset_rgb", bus.trk_rgb, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_inputs();

        set_enable(0);
        run_frame(0, 1);
        run_frame(2, 1);
        run_frame(1, 1);
        run_frame(0, 1);
        run_frame(0, 0);
        run_frame(0, 0);
        run_frame(1, 0);
        set_enable(2);
        repeat (7) run_frame(0, 1);
        repeat (30) begin
            if ($urandom_range(4, 0) == 0) set_enable(int'($urandom_range(3, 0)));
            run_frame(int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        set_enable(0);
        for (int i = 0; i < 4; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_sof   = (i == 0);
            bus.pix_rgb   = 24'($urandom);
            wr_q.push_back(bus.pix_rgb);
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        wr_q.delete();
        idle_inputs();
        reset_model();
        @(negedge clock);
        check_outputs("midreset");
        chk("midreset_wr_en", bus.trk_wr_en, 0);
        wr_target = writes_seen;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        m_skip = 0;
        run_frame(0, 1);

        chk("wr_q_empty", wr_q.size(), 0);
        chk("box_q_empty", box_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tracking_frame_ctrl.md
# tracking_frame_ctrl

Frame-level sequencer that sits between the camera pixel stream and the colour-blob `tracking` block. It selects which frames are fed to the tracker (decimation), guarantees the tracker always receives exactly WIDTH*HEIGHT pixels per fed frame (padding short or lossy frames) so its raster counters never desynchronise, and waits for the tracker's result or a timeout. It then publishes a held, qualified bounding box with frame statistics to the overlay/display logic.

## Interface
- WIDTH, 640, pixels per line fed to tracker (must match tracker's WIDTH)
- HEIGHT, 480, lines per frame (must match tracker's HEIGHT)
- RES_TIMEOUT, 8192, cycles to wait in WAIT_RES for `trk_valid` after last write
- MISS_LIMIT, 4, consecutive clean no-target frames before `box_valid` clears (1..15)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_enable  in  1  run enable; sampled only at frame boundaries
- cfg_decim  in  4  feed one frame of every cfg_decim+1
- pix_valid  in  1  camera pixel qualifier
- pix_sof  in  1  first pixel of frame (qualified by pix_valid)
- pix_rgb  in  24  {R,G,B}
- trk_full  in  1  tracker input FIFO full
- trk_wr_en  out  1  tracker FIFO write (combinational)
- trk_rgb  out  24  tracker pixel data (combinational)
- trk_valid  in  1  tracker result pulse
- trk_cx, trk_cy, trk_w, trk_h  in  12 each  tracker result
- box_valid  out  1  held box is current
- box_cx, box_cy, box_w, box_h  out  12 each  held box
- result_strobe  out  1  one-cycle pulse when box updated
- busy  out  1  state is FEED, PAD or WAIT_RES
- fed_frames  out  16  clean frames completed, saturating
- err_frames  out  16  corrupt frames, saturating

## Operation
- States: IDLE, WAIT_SOF, FEED, PAD, WAIT_RES. Reset -> IDLE.
- IDLE: cfg_enable=1 -> WAIT_SOF; decim_cnt=0.
- WAIT_SOF: cfg_enable=0 -> IDLE. On pix_valid&pix_sof: if decim_cnt!=0, decrement, stay. Else reload decim_cnt=cfg_decim, clear corrupt, wr_cnt=0, write this pixel (if !trk_full), -> FEED.
- FEED: each pix_valid&!pix_sof pixel: trk_full=0 -> write, wr_cnt++; trk_full=1 -> pixel dropped, corrupt=1. When wr_cnt reaches WIDTH*HEIGHT -> WAIT_RES (later pixels of that frame ignored). pix_sof before completion -> short frame: corrupt=1, SOF pixel not written, that new frame is not fed, -> PAD.
- PAD: trk_rgb=0 (never matches target colour), trk_wr_en=!trk_full, wr_cnt++ per write, input ignored; wr_cnt==WIDTH*HEIGHT -> WAIT_RES.
- trk_rgb = pix_rgb except in PAD. trk_wr_en never asserted while trk_full=1.
- WAIT_RES: timer counts from 0; input pixels/SOFs ignored (decim_cnt unchanged).
  - trk_valid & !corrupt: latch box_*, box_valid=1, result_strobe, miss_cnt=0, fed_frames++.
  - trk_valid & corrupt: discard, err_frames++.
  - timer==RES_TIMEOUT-1 without valid: corrupt -> err_frames++; else fed_frames++, miss_cnt++, miss_cnt==MISS_LIMIT -> box_valid=0 (box_* retained).
  - Either exit -> WAIT_SOF if cfg_enable else IDLE.
- cfg_enable=0 in FEED/PAD/WAIT_RES has no effect until frame completes.
- wr_cnt width $clog2(WIDTH*HEIGHT+1); counters saturate at 16'hFFFF.

## Timing
- Reset values: box_valid 0, box_* 0, result_strobe 0, fed_frames/err_frames 0, busy 0, trk_wr_en 0, trk_rgb 0 (trk_* outputs driven from IDLE state).
- Pixel to trk_wr_en: 0 cycles (combinational from pix_valid, pix_sof, trk_full, state).
- trk_valid to box_*/result_strobe: 1 cycle (registered).
- WAIT_RES entered the cycle after final write; timeout exit RES_TIMEOUT cycles later.
- trk_valid while not in WAIT_RES ignored.
- Reset mid-frame: all state cleared; tracker must be reset together (shared reset).

## Test plan
- WIDTH=4,HEIGHT=2,decim=0, clean 8-pixel frame, tracker model pulses valid cx=2,cy=1,w=3,h=2 -> 8 writes, strobe, box=(2,1,3,2), box_valid=1, fed_frames=1.
- decim=2, 7 frames -> frames 1,4,7 fed (8 writes each); others zero writes.
- Short frame: SOF after 5 pixels -> 3 zero pads, valid discarded, err_frames=1, box unchanged; that interrupted next frame not fed.
- trk_full high for 2 pixel cycles in FEED -> 2 dropped, 2 pads, total writes 8, frame counted corrupt.
- MISS_LIMIT=2, RES_TIMEOUT=16, two clean frames without valid -> box_valid 1->0 at second timeout, fed_frames +2.
- Reset asserted mid-FEED -> all outputs to reset values next edge; new SOF after release fed from wr_cnt=0.
